// File: rtl/pipe_scroll_collide.sv
// Scrolling pipe field for the bird game: an 8x8 obstacle grid that shifts one
// column toward the bird on every accepted scroll tick, spawns pipes with a
// pseudo-random gap at the entry edge, detects bird/pipe overlap and keeps score.
module pipe_scroll_collide #(
  parameter int         BIRD_COL  = 2,
  parameter int         GAP_ROWS  = 3,
  parameter int         SPACING   = 4,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic        start_i,
  input  logic        tick_i,
  input  logic [7:0]  position_i,
  input  logic        gameOver_i,
  output logic        crash_o,
  output logic [63:0] pipe_map_o,
  output logic [7:0]  score_o
);

  // The gap base is lfsr mod (9 - GAP_ROWS), so the gap always fits inside rows 0..7.
  localparam logic [7:0] GAP_MODULUS = 8'(9 - GAP_ROWS);
  localparam logic [7:0] GAP_ONES    = 8'((1 << GAP_ROWS) - 1);
  localparam logic [3:0] CNT_RELOAD  = 4'(SPACING - 1);

  logic [63:0] pipeMap_q, pipeMap_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [7:0]  score_q, score_d;
  logic        crash_q, crash_d;

  logic [7:0]  birdColumn;
  logic        hit;
  logic        tickAccepted;
  logic        spawn;
  logic [7:0]  gapBase;
  logic [7:0]  gapBits;
  logic [7:0]  pipeMask;
  logic [7:0]  lfsrNext;
  logic        scoreInc;

  // Collision detection and tick qualification; a crashed or finished game freezes scrolling.
  always_comb begin
    birdColumn   = pipeMap_q[8*BIRD_COL +: 8];
    hit          = |(birdColumn & position_i);
    tickAccepted = tick_i & start_i & ~gameOver_i & ~crash_q;
    spawn        = tickAccepted && (cnt_q == 4'd0);
    scoreInc     = tickAccepted && (birdColumn != 8'h00) && !hit;
  end

  // New pipe column: all rows blocked except a GAP_ROWS-high opening chosen by the LFSR.
  always_comb begin
    gapBase  = lfsr_q % GAP_MODULUS;
    gapBits  = GAP_ONES << gapBase;
    pipeMask = ~gapBits;
    lfsrNext = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Next-state logic: shift the grid, run the spawn counter, advance the LFSR after use.
  always_comb begin
    pipeMap_d = pipeMap_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    score_d   = score_q;
    crash_d   = crash_q | hit;

    if (tickAccepted) begin
      pipeMap_d[55:0] = pipeMap_q[63:8];
      if (spawn) begin
        pipeMap_d[63:56] = pipeMask;
        cnt_d            = CNT_RELOAD;
        lfsr_d           = lfsrNext;
      end else begin
        pipeMap_d[63:56] = 8'h00;
        cnt_d            = cnt_q - 4'd1;
      end
      if (scoreInc && (score_q != 8'hFF)) begin
        score_d = score_q + 8'd1;
      end
    end
  end

  // State registers with synchronous reset back to an empty field and seeded LFSR.
  always_ff @(posedge Clock) begin
    if (reset) begin
      pipeMap_q <= 64'h0;
      cnt_q     <= 4'd0;
      lfsr_q    <= LFSR_SEED;
      score_q   <= 8'd0;
      crash_q   <= 1'b0;
    end else begin
      pipeMap_q <= pipeMap_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      score_q   <= score_d;
      crash_q   <= crash_d;
    end
  end

  assign crash_o    = crash_q;
  assign pipe_map_o = pipeMap_q;
  assign score_o    = score_q;

endmodule

// File: tb/tb_pipe_scroll_collide.sv
// Directed bench for pipe_scroll_collide: table of per-cycle vectors plus
// hand-written sequences for crash, reset-during-crash and score saturation.
module tb_pipe_scroll_collide;

  logic        Clock;
  logic        reset;
  logic        start_i;
  logic        tick_i;
  logic [7:0]  position_i;
  logic        gameOver_i;
  logic        crash_o;
  logic [63:0] pipe_map_o;
  logic [7:0]  score_o;

  int testsRun;
  int testsFailed;

  typedef struct {
    string       name;
    logic        start;
    logic        gameOver;
    logic        tick;
    logic [7:0]  pos;
    logic [63:0] expMap;
    logic        expCrash;
    logic [7:0]  expScore;
  } vec_t;

  vec_t vecs[$];

  // Hand-computed grid snapshots after tick k with default parameters.
  localparam logic [63:0] M1  = 64'hC700_0000_0000_0000;
  localparam logic [63:0] M2  = 64'h00C7_0000_0000_0000;
  localparam logic [63:0] M3  = 64'h0000_C700_0000_0000;
  localparam logic [63:0] M4  = 64'h0000_00C7_0000_0000;
  localparam logic [63:0] M5  = 64'hE300_0000_C700_0000;
  localparam logic [63:0] M6  = 64'h00E3_0000_00C7_0000;
  localparam logic [63:0] M7  = 64'h0000_E300_0000_C700;
  localparam logic [63:0] M8  = 64'h0000_00E3_0000_00C7;
  localparam logic [63:0] M9  = 64'h1F00_0000_E300_0000;
  localparam logic [63:0] M10 = 64'h001F_0000_00E3_0000;
  localparam logic [63:0] M11 = 64'h0000_1F00_0000_E300;

  pipe_scroll_collide dut (
    .Clock      (Clock),
    .reset      (reset),
    .start_i    (start_i),
    .tick_i     (tick_i),
    .position_i (position_i),
    .gameOver_i (gameOver_i),
    .crash_o    (crash_o),
    .pipe_map_o (pipe_map_o),
    .score_o    (score_o)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic vec_t mk(string n, logic s, logic g, logic t, logic [7:0] p,
                              logic [63:0] m, logic c, logic [7:0] sc);
    vec_t v;
    v.name = n; v.start = s; v.gameOver = g; v.tick = t; v.pos = p;
    v.expMap = m; v.expCrash = c; v.expScore = sc;
    return v;
  endfunction

  // Drive one cycle of inputs on the falling edge, then wait past the rising edge.
  task automatic applyStimulus(input logic s, input logic g, input logic t, input logic [7:0] p);
    @(negedge Clock);
    start_i    = s;
    gameOver_i = g;
    tick_i     = t;
    position_i = p;
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string n, input logic [63:0] m, input logic c, input logic [7:0] sc);
    testsRun++;
    if (pipe_map_o !== m) begin
      testsFailed++;
      $display("[TB] FAIL %s pipe_map: got %h expected %h", n, pipe_map_o, m);
    end
    testsRun++;
    if (crash_o !== c) begin
      testsFailed++;
      $display("[TB] FAIL %s crash: got %b expected %b", n, crash_o, c);
    end
    testsRun++;
    if (score_o !== sc) begin
      testsFailed++;
      $display("[TB] FAIL %s score: got %0d expected %0d", n, score_o, sc);
    end
  endtask

  task automatic doReset();
    @(negedge Clock);
    reset  = 1'b1;
    tick_i = 1'b0;
    @(posedge Clock);
    #1;
    checkOutput("reset", 64'h0, 1'b0, 8'd0);
    @(negedge Clock);
    reset = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    start_i     = 1'b0;
    tick_i      = 1'b0;
    position_i  = 8'h00;
    gameOver_i  = 1'b0;

    // Main run with bird at row 4: both C7 and E3 pipes pass safely.
    vecs.push_back(mk("t1_spawn",   1, 0, 1, 8'h10, M1,  0, 0));
    vecs.push_back(mk("t2",         1, 0, 1, 8'h10, M2,  0, 0));
    vecs.push_back(mk("idle",       1, 0, 0, 8'h10, M2,  0, 0));
    vecs.push_back(mk("t3",         1, 0, 1, 8'h10, M3,  0, 0));
    vecs.push_back(mk("t4",         1, 0, 1, 8'h10, M4,  0, 0));
    vecs.push_back(mk("t5_spawnE3", 1, 0, 1, 8'h10, M5,  0, 0));
    vecs.push_back(mk("startLow",   0, 0, 1, 8'h10, M5,  0, 0));
    vecs.push_back(mk("gameOver",   1, 1, 1, 8'h10, M5,  0, 0));
    vecs.push_back(mk("t6_col2",    1, 0, 1, 8'h10, M6,  0, 0));
    vecs.push_back(mk("t7_score",   1, 0, 1, 8'h10, M7,  0, 1));
    vecs.push_back(mk("t8",         1, 0, 1, 8'h10, M8,  0, 1));
    vecs.push_back(mk("t9_spawn1F", 1, 0, 1, 8'h10, M9,  0, 1));
    vecs.push_back(mk("t10",        1, 0, 1, 8'h10, M10, 0, 1));
    vecs.push_back(mk("t11_score2", 1, 0, 1, 8'h10, M11, 0, 2));

    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start, vecs[i].gameOver, vecs[i].tick, vecs[i].pos);
      checkOutput(vecs[i].name, vecs[i].expMap, vecs[i].expCrash, vecs[i].expScore);
    end

    // Bird at row 7 collides with the C7 pipe once it reaches column 2.
    doReset();
    for (int k = 1; k <= 6; k++) applyStimulus(1, 0, 1, 8'h80);
    checkOutput("crash_t6", M6, 1'b0, 8'd0);
    applyStimulus(1, 0, 0, 8'h80);
    checkOutput("crash_set", M6, 1'b1, 8'd0);
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 1, 8'h80);
    checkOutput("crash_frozen", M6, 1'b1, 8'd0);
    applyStimulus(1, 0, 1, 8'h00);
    checkOutput("crash_sticky", M6, 1'b1, 8'd0);

    // Reset while crashed, then the first tick repeats the initial spawn.
    doReset();
    applyStimulus(1, 0, 1, 8'h10);
    checkOutput("reset_respawn", M1, 1'b0, 8'd0);

    // Tick in the same cycle as the hit is accepted, with no score; later ticks are blocked.
    doReset();
    for (int k = 1; k <= 6; k++) applyStimulus(1, 0, 1, 8'h80);
    applyStimulus(1, 0, 1, 8'h80);
    checkOutput("hit_tick", M7, 1'b1, 8'd0);
    applyStimulus(1, 0, 1, 8'h80);
    checkOutput("hit_block", M7, 1'b1, 8'd0);

    // Score saturation: pipe n is passed on tick 4n+3, so 255 is reached on tick 1023.
    doReset();
    for (int k = 1; k <= 1030; k++) begin
      applyStimulus(1, 0, 1, 8'h00);
      if (k == 1022) begin
        testsRun++;
        if (score_o !== 8'd254) begin
          testsFailed++;
          $display("[TB] FAIL sat_pre score: got %0d expected 254", score_o);
        end
      end
      if (k == 1023 || k == 1030) begin
        testsRun++;
        if (score_o !== 8'd255) begin
          testsFailed++;
          $display("[TB] FAIL sat_hold tick %0d score: got %0d expected 255", k, score_o);
        end
      end
    end
    testsRun++;
    if (crash_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL pos0_nohit crash: got %b expected 0", crash_o);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
